// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch stage.
//   OP_HLT / OP_SW : opcodes (instr[15:12]) that fetch has to recognise
//   NOP_INSTR      : instruction word carried by an IF/ID bubble
//   ST_*           : fetch FSM state encoding
package fetch_pkg;

   localparam logic [3:0]  OP_HLT    = 4'hF;
   localparam logic [3:0]  OP_SW     = 4'h9;
   localparam logic [15:0] NOP_INSTR = 16'h0000;

   localparam logic [1:0]  ST_FETCH   = 2'd0;
   localparam logic [1:0]  ST_DISCARD = 2'd1;
   localparam logic [1:0]  ST_HALT    = 2'd2;

   // Second source register: stores name it in [11:8], everything else in [3:0].
   function automatic logic [3:0] rt_field(input logic [15:0] instr);
      return (instr[15:12] == OP_SW) ? instr[11:8] : instr[3:0];
   endfunction

endpackage

// File: rtl/fetch_unit_if_id_pipe.sv
// IF/ID pipeline register with hold/flush and register-field extraction.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   wen, flush          : load enable; flush forces a bubble and wins over wen
//   ld_instr/ld_pc_plus2/ld_valid : value offered by fetch this cycle
//   instr, pc_plus2, valid        : registered IF/ID contents
//   rs, rt              : source register fields decoded from the registered word
module fetch_unit_if_id_pipe
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wen,
   input  logic        flush,
   input  logic [15:0] ld_instr,
   input  logic [15:0] ld_pc_plus2,
   input  logic        ld_valid,
   output logic [15:0] instr,
   output logic [15:0] pc_plus2,
   output logic        valid,
   output logic [3:0]  rs,
   output logic [3:0]  rt
);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         instr    <= NOP_INSTR;
         pc_plus2 <= 16'h0000;
         valid    <= 1'b0;
      end else if (wen) begin
         instr    <= ld_instr;
         pc_plus2 <= ld_pc_plus2;
         valid    <= ld_valid;
      end
   end

   assign rs = instr[7:4];
   assign rt = rt_field(instr);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, I-memory request port and IF/ID register.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   pc_wen, if_id_wen, if_id_flush : hazard-unit hold/flush controls
//   br_taken, br_target          : fetch redirect
//   imem_req/addr/ready/data     : instruction-memory port (ready same cycle on hit)
//   if_id_*                      : IF/ID contents and decoded rs/rt
//   fetch_stall, halted          : status
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_FETCH   | request at pc every cycle, accept word when allowed
// ST_DISCARD | branch arrived mid-miss; finish old request, drop it, jump
// ST_HALT    | HLT accepted; no requests until a branch or reset
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_wen,
   input  logic        if_id_wen,
   input  logic        if_id_flush,
   input  logic        br_taken,
   input  logic [15:0] br_target,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_data,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc_plus2,
   output logic        if_id_valid,
   output logic [3:0]  if_id_rs,
   output logic [3:0]  if_id_rt,
   output logic        fetch_stall,
   output logic        halted
);

   logic [1:0]  state, state_nxt;
   logic [15:0] pc, pc_nxt;
   logic [15:0] redirect_pc, redirect_nxt;
   logic [15:0] pc_plus2;
   logic        accept;

   assign pc_plus2 = pc + 16'd2;

   // A word is only consumed when every stage downstream can take it; in any
   // other ready cycle it is dropped and the same pc is fetched again.
   assign accept = (state == ST_FETCH) && !br_taken && imem_ready &&
                   pc_wen && if_id_wen && !if_id_flush;

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      redirect_nxt = redirect_pc;
      case (state)
         ST_FETCH: begin
            if (br_taken) begin
               if (imem_ready) begin
                  pc_nxt = br_target;
               end else begin
                  // Memory still owes us this word; remember where to go.
                  redirect_nxt = br_target;
                  state_nxt    = ST_DISCARD;
               end
            end else if (accept) begin
               if (imem_data[15:12] == OP_HLT) state_nxt = ST_HALT;
               else                            pc_nxt    = pc_plus2;
            end
         end
         ST_DISCARD: begin
            if (br_taken) redirect_nxt = br_target;
            if (imem_ready) begin
               pc_nxt    = br_taken ? br_target : redirect_pc;
               state_nxt = ST_FETCH;
            end
         end
         ST_HALT: begin
            if (br_taken) begin
               pc_nxt    = br_target;
               state_nxt = ST_FETCH;
            end
         end
         default: state_nxt = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_FETCH;
         pc          <= RESET_PC;
         redirect_pc <= 16'h0000;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         redirect_pc <= redirect_nxt;
      end
   end

   assign imem_req    = (state != ST_HALT);
   assign imem_addr   = pc;
   assign fetch_stall = imem_req & ~imem_ready;
   assign halted      = (state == ST_HALT);

   fetch_unit_if_id_pipe u_if_id (
      .clk         (clk),
      .rst         (rst),
      .wen         (if_id_wen),
      .flush       (if_id_flush),
      .ld_instr    (accept ? imem_data : NOP_INSTR),
      .ld_pc_plus2 (accept ? pc_plus2  : 16'h0000),
      .ld_valid    (accept),
      .instr       (if_id_instr),
      .pc_plus2    (if_id_pc_plus2),
      .valid       (if_id_valid),
      .rs          (if_id_rs),
      .rt          (if_id_rt)
   );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, pc_wen, if_id_wen, if_id_flush, br_taken;
   logic [15:0] br_target;
   logic        imem_req, imem_ready;
   logic [15:0] imem_addr, imem_data;
   logic [15:0] if_id_instr, if_id_pc_plus2;
   logic        if_id_valid;
   logic [3:0]  if_id_rs, if_id_rt;
   logic        fetch_stall, halted;

   // Memory model: each word equals its own address unless overridden.
   logic        ovr_en;
   logic [15:0] ovr_word;
   assign imem_data = ovr_en ? ovr_word : imem_addr;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(16'h0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_wen         (pc_wen),
      .if_id_wen      (if_id_wen),
      .if_id_flush    (if_id_flush),
      .br_taken       (br_taken),
      .br_target      (br_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_data      (imem_data),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus2 (if_id_pc_plus2),
      .if_id_valid    (if_id_valid),
      .if_id_rs       (if_id_rs),
      .if_id_rt       (if_id_rt),
      .fetch_stall    (fetch_stall),
      .halted         (halted)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; pc_wen = 1'b1; if_id_wen = 1'b1; if_id_flush = 1'b0;
      br_taken = 1'b0; br_target = 16'h0000; imem_ready = 1'b1;
      ovr_en = 1'b0; ovr_word = 16'h0000;
      tick(); tick();

      chk("rst_addr",   imem_addr,   16'h0000);
      chk("rst_req",    imem_req,    1);
      chk("rst_halted", halted,      0);
      chk("rst_valid",  if_id_valid, 0);
      chk("rst_instr",  if_id_instr, 16'h0000);
      chk("rst_stall",  fetch_stall, 0);
      rst = 1'b0;

      // Back-to-back hits.
      tick();
      chk("hit_addr2", imem_addr, 16'h0002);
      chk("hit_pp2",   if_id_pc_plus2, 16'h0002);
      chk("hit_valid", if_id_valid, 1);
      tick();
      chk("hit_addr4", imem_addr, 16'h0004);
      chk("hit_pp4",   if_id_pc_plus2, 16'h0004);
      chk("hit_instr", if_id_instr, 16'h0002);

      // Three-cycle miss at 0x0004.
      imem_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("miss_stall", fetch_stall, 1);
         tick();
         chk("miss_addr",  imem_addr, 16'h0004);
         chk("miss_valid", if_id_valid, 0);
      end
      imem_ready = 1'b1;
      tick();
      chk("miss_instr", if_id_instr, 16'h0004);
      chk("miss_pp2",   if_id_pc_plus2, 16'h0006);
      chk("miss_vld",   if_id_valid, 1);
      chk("miss_next",  imem_addr, 16'h0006);
      tick();
      chk("addr8", imem_addr, 16'h0008);

      // Load-use hold for two cycles at 0x0008.
      pc_wen = 1'b0; if_id_wen = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("hold_addr",  imem_addr, 16'h0008);
         chk("hold_instr", if_id_instr, 16'h0006);
         chk("hold_valid", if_id_valid, 1);
      end
      pc_wen = 1'b1; if_id_wen = 1'b1;
      tick();
      chk("resume_instr", if_id_instr, 16'h0008);
      chk("resume_addr",  imem_addr, 16'h000A);
      tick();
      chk("resume_instr2", if_id_instr, 16'h000A);
      chk("addrC", imem_addr, 16'h000C);

      // HLT at 0x000C.
      ovr_en = 1'b1; ovr_word = 16'hF000;
      tick();
      ovr_en = 1'b0;
      chk("hlt_instr",  if_id_instr, 16'hF000);
      chk("hlt_halted", halted, 1);
      chk("hlt_req",    imem_req, 0);
      chk("hlt_addr",   imem_addr, 16'h000C);
      tick();
      chk("hlt_hold",   halted, 1);
      chk("hlt_bubble", if_id_valid, 0);
      chk("hlt_addr2",  imem_addr, 16'h000C);
      br_taken = 1'b1; br_target = 16'h0020;
      tick();
      br_taken = 1'b0;
      chk("unhalt",      halted, 0);
      chk("unhalt_req",  imem_req, 1);
      chk("unhalt_addr", imem_addr, 16'h0020);
      tick();
      chk("post_hlt_instr", if_id_instr, 16'h0020);
      chk("post_hlt_pp2",   if_id_pc_plus2, 16'h0022);

      // Redirect on a hit goes to 0x0010 next cycle; fetched word dropped.
      br_taken = 1'b1; br_target = 16'h0010;
      tick();
      br_taken = 1'b0;
      chk("br_hit_addr",  imem_addr, 16'h0010);
      chk("br_hit_valid", if_id_valid, 0);

      // Branch to 0x0040 arriving during a miss at 0x0010.
      imem_ready = 1'b0;
      tick();
      chk("bm_addr0", imem_addr, 16'h0010);
      br_taken = 1'b1; br_target = 16'h0040;
      tick();
      br_taken = 1'b0; br_target = 16'h0000;
      chk("bm_addr1",  imem_addr, 16'h0010);
      chk("bm_stall",  fetch_stall, 1);
      chk("bm_valid1", if_id_valid, 0);
      tick();
      chk("bm_addr2",  imem_addr, 16'h0010);
      imem_ready = 1'b1;
      tick();
      chk("bm_redir",  imem_addr, 16'h0040);
      chk("bm_drop",   if_id_valid, 0);
      tick();
      chk("bm_instr",  if_id_instr, 16'h0040);
      chk("bm_pp2",    if_id_pc_plus2, 16'h0042);

      // rs/rt extraction.
      ovr_en = 1'b1; ovr_word = 16'h9A53;
      tick();
      chk("sw_rs", if_id_rs, 4'h5);
      chk("sw_rt", if_id_rt, 4'hA);
      ovr_word = 16'h0A53;
      tick();
      chk("add_rs", if_id_rs, 4'h5);
      chk("add_rt", if_id_rt, 4'h3);
      ovr_en = 1'b0;

      // Flush forces a bubble even with if_id_wen high.
      if_id_flush = 1'b1;
      tick();
      if_id_flush = 1'b0;
      chk("flush_valid", if_id_valid, 0);
      chk("flush_instr", if_id_instr, 16'h0000);

      // PC wrap at 0xFFFE.
      br_taken = 1'b1; br_target = 16'hFFFE;
      tick();
      br_taken = 1'b0;
      chk("wrap_addr0", imem_addr, 16'hFFFE);
      ovr_en = 1'b1; ovr_word = 16'h0123;
      tick();
      ovr_en = 1'b0;
      chk("wrap_addr1", imem_addr, 16'h0000);
      chk("wrap_pp2",   if_id_pc_plus2, 16'h0000);
      chk("wrap_instr", if_id_instr, 16'h0123);

      // Reset in the middle of a miss.
      tick();
      imem_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; imem_ready = 1'b1;
      chk("rstmid_addr",  imem_addr, 16'h0000);
      chk("rstmid_valid", if_id_valid, 0);
      chk("rstmid_req",   imem_req, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage pipeline: owns the PC, issues requests to the instruction-memory/I-cache port, and owns the IF/ID pipeline register. It obeys the hold/flush controls driven by the hazard-detection logic and supplies that logic with the ID-stage register fields. Fetch stalls on I-cache misses, redirects on taken branches, and stops at HLT.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- pc_wen  in  1  0 = hold PC (load-to-use stall)
- if_id_wen  in  1  0 = hold IF/ID contents
- if_id_flush  in  1  1 = load bubble into IF/ID (takes priority over if_id_wen)
- br_taken  in  1  redirect fetch to br_target
- br_target  in  16  branch destination
- imem_req  out  1  fetch request, held until imem_ready
- imem_addr  out  16  fetch address, stable while imem_req=1
- imem_ready  in  1  data valid this cycle (same-cycle on hit)
- imem_data  in  16  fetched instruction
- if_id_instr  out  16  instruction in ID
- if_id_pc_plus2  out  16  PC+2 of that instruction
- if_id_valid  out  1  0 = bubble
- if_id_rs  out  4  instr[7:4]
- if_id_rt  out  4  instr[11:8] when opcode=SW, else instr[3:0]
- fetch_stall  out  1  imem_req & ~imem_ready
- halted  out  1  state==HALT

## Operation
- States: FETCH, DISCARD, HALT. Reset: FETCH, pc=RESET_PC, redirect_pc=0, IF/ID instr=16'h0000, pc_plus2=0, valid=0; hence halted=0, imem_req=1, imem_addr=RESET_PC.
- Per-cycle priority: rst > br_taken > imem_ready/pc_wen.
- FETCH: imem_req=1, imem_addr=pc.
  - br_taken & imem_ready: pc<=br_target, stay FETCH; fetched word dropped.
  - br_taken & ~imem_ready: redirect_pc<=br_target, go DISCARD (outstanding request is never abandoned).
  - imem_ready & pc_wen & if_id_wen & ~if_id_flush: IF/ID<={imem_data, pc+2, valid=1}; if opcode==HLT (4'hF) pc holds and go HALT, else pc<=pc+2.
  - imem_ready & ~pc_wen: pc holds, word dropped, same address refetched next cycle.
  - ~imem_ready: pc holds; if if_id_wen=1, bubble loaded into IF/ID.
- DISCARD: imem_req=1, imem_addr=pc (old). br_taken overwrites redirect_pc. On imem_ready: pc<=redirect_pc (or br_target if br_taken same cycle), data dropped, go FETCH. IF/ID takes bubble whenever if_id_wen=1.
- HALT: imem_req=0; IF/ID takes bubble when if_id_wen=1. br_taken (older branch squashing HLT): pc<=br_target, go FETCH. Otherwise remain until rst.
- IF/ID update: if_id_flush -> bubble; else if if_id_wen -> load (instruction or bubble per above); else hold.
- Bubble = {instr 16'h0000, pc_plus2 0, valid 0}.
- PC arithmetic: 16-bit, pc+2 wraps 16'hFFFE -> 16'h0000 silently.

## Timing
- Hit: one instruction per cycle; instruction fetched in cycle N visible on if_id_* in N+1.
- Miss: fetch_stall=1 each cycle imem_ready=0; address/req stable throughout.
- Redirect latency: br_taken in cycle N with hit -> imem_addr=br_target in N+1; during miss, first cycle after imem_ready.
- if_id_rs/if_id_rt combinational from registered IF/ID; no imem-to-output comb path except fetch_stall.
- rst mid-miss: request dropped; memory side reset by same rst.

## Structure
- Shared package: OP_HLT=4'hF, OP_SW=4'h9, NOP_INSTR=16'h0000, fetch-state encoding.
- Sub-module if_id_pipe: IF/ID register with wen/flush/bubble and rs/rt field extraction; FSM and PC live in fetch_unit.

## Test plan
- Reset, imem_ready=1 constant, memory returns pc-indexed words -> imem_addr 0,2,4,6 on consecutive cycles; if_id_pc_plus2 2,4,6.
- Miss of 3 cycles at 16'h0004 -> fetch_stall=1 for 3 cycles, 3 bubbles, then instruction at 0x0004 with valid=1, next addr 0x0006.
- pc_wen=if_id_wen=0 for 2 cycles at pc=0x0008 -> imem_addr stays 0x0008, IF/ID held, resumes with no duplicate or skipped instruction.
- br_taken (target 0x0040) during miss at 0x0010 -> addr stays 0x0010 until ready, data dropped, next addr 0x0040, no valid IF/ID from 0x0010.
- HLT (16'hF000) at 0x000C -> halted=1, imem_req=0, pc stays 0x000C; later br_taken target 0x0020 -> halted=0, imem_addr=0x0020.
- Opcode SW word 16'h9A53 in IF/ID -> if_id_rs=5, if_id_rt=0xA; ADD word 16'h0A53 -> rt=3.
